byte_serial_add_seq: RTL and testbench

//  Multi-cycle sequencer that performs a WIDTH-bit add or subtract by reusing one

---
 rtl/byte_serial_add_seq.sv | 148 ++++++++++++++
 tb/tb_byte_serial_add_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_add_seq.sv
// Byte-serial WIDTH-bit add/subtract sequencer that reuses one 8-bit ripple adder,
// processing one byte per cycle, LSB first, with valid/ready handshakes on both sides.

module fulladder_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);
    // Ripple carry chain held in a block-local variable to keep it a simple chain.
    always_comb begin
        logic c;
        c     = i_cin;
        o_sum = '0;
        for (int i = 0; i < 8; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ c;
            c        = (i_a[i] & i_b[i]) | (i_a[i] & c) | (i_b[i] & c);
        end
        o_cout = c;
    end
endmodule

module byte_serial_add_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        r_state, w_state_nxt;
    logic [IDXW-1:0]               r_idx, w_idx_nxt;
    logic [NBYTES-1:0][7:0]        r_a, w_a_nxt;
    logic [NBYTES-1:0][7:0]        r_b, w_b_nxt;
    logic [NBYTES-1:0][7:0]        r_sum, w_sum_nxt;
    logic                          r_carry, w_carry_nxt;
    logic                          r_cout, w_cout_nxt;
    logic                          r_in_ready, w_in_ready_nxt;
    logic                          r_out_valid, w_out_valid_nxt;

    logic [7:0]                    w_add_sum;
    logic                          w_add_cout;

    fulladder_8bit u_add (
        .i_a    (r_a[r_idx]),
        .i_b    (r_b[r_idx]),
        .i_cin  (r_carry),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_sum       <= w_sum_nxt;
            r_carry     <= w_carry_nxt;
            r_cout      <= w_cout_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state and next-output logic; handshake flags are precomputed so they stay registered.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_sum_nxt       = r_sum;
        w_carry_nxt     = r_carry;
        w_cout_nxt      = r_cout;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_a_nxt        = a;
                    w_b_nxt        = sub ? ~b : b;
                    w_carry_nxt    = sub;
                    w_idx_nxt      = '0;
                    w_in_ready_nxt = 1'b0;
                    w_state_nxt    = RUN;
                end
            end
            RUN: begin
                w_sum_nxt[r_idx] = w_add_sum;
                w_carry_nxt      = w_add_cout;
                if (r_idx == IDXW'(NBYTES - 1)) begin
                    w_cout_nxt      = w_add_cout;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else begin
                    w_idx_nxt = r_idx + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_in_ready_nxt  = 1'b1;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Directed and randomized checks of byte_serial_add_seq at WIDTH=32 against
// hand-computed values and a plain 33-bit arithmetic reference.

module tb_byte_serial_add_seq;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    byte_serial_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Present one operand bundle, take the accepting edge, then wait for out_valid.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          output int lat);
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b, want 1 0 0 0",
                     in_ready, out_valid, sum, cout);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_carry_wrap();
        int lat;
        out_ready = 1'b1;
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, lat);
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL wrap_latency: got %0d want 4", lat);
        end
        vectors++;
        if (sum !== 32'h0 || cout !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_result: got %h/%b want 00000000/1", sum, cout);
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_return: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_sub();
        int lat;
        out_ready = 1'b1;
        run_op(32'd5, 32'd7, 1'b1, lat);
        vectors++;
        if (sum !== 32'hFFFF_FFFE || cout !== 1'b0 || lat !== 4) begin
            miscompares++;
            $display("FAIL sub_5_7: got %h/%b lat %0d want fffffffe/0 lat 4", sum, cout, lat);
        end
        tick();
        run_op(32'd7, 32'd5, 1'b1, lat);
        vectors++;
        if (sum !== 32'h2 || cout !== 1'b1 || lat !== 4) begin
            miscompares++;
            $display("FAIL sub_7_5: got %h/%b lat %0d want 00000002/1 lat 4", sum, cout, lat);
        end
        tick();
    endtask

    task automatic test_stall();
        int lat;
        out_ready = 1'b0;
        run_op(32'h1234_5678, 32'h0FED_CBA8, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || sum !== 32'h2222_2220 || cout !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: ov=%b sum=%h cout=%b ir=%b want 1 22222220 0 0",
                         i, out_valid, sum, cout, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_input_change();
        int n;
        out_ready = 1'b1;
        a = 32'h0000_00FF; b = 32'h1; sub = 1'b0; in_valid = 1'b1;
        tick();
        n = 0;
        while (!out_valid && n < 20) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL chg_in_ready[%0d]: got %b want 0", n, in_ready);
            end
            tick();
            n++;
        end
        vectors++;
        if (sum !== 32'h0000_0100 || cout !== 1'b0 || n !== 4) begin
            miscompares++;
            $display("FAIL chg_result: got %h/%b lat %0d want 00000100/0 lat 4", sum, cout, n);
        end
        in_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL chg_idle: ir=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_abort();
        int lat;
        out_ready = 1'b1;
        a = 32'hDEAD_BEEF; b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_reset: ov=%b sum=%h cout=%b ir=%b want 0 0 0 1",
                     out_valid, sum, cout, in_ready);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0 || sum !== '0) begin
                miscompares++;
                $display("FAIL abort_stale[%0d]: ov=%b sum=%h want 0 0", i, out_valid, sum);
            end
        end
        run_op(32'h1, 32'h1, 1'b0, lat);
        vectors++;
        if (sum !== 32'h2 || cout !== 1'b0 || lat !== 4) begin
            miscompares++;
            $display("FAIL abort_next: got %h/%b lat %0d want 00000002/0 lat 4", sum, cout, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av, bv;
        logic         sv;
        logic [W:0]   ref_r;
        int           acc, prev, n;
        out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 1000; i++) begin
            av = $urandom; bv = $urandom; sv = 1'($urandom_range(0, 1));
            if (i == 0) begin av = 32'h8000_0000; bv = 32'h8000_0000; sv = 1'b0; end
            if (i == 1) begin av = 32'h0; bv = 32'h0; sv = 1'b1; end
            a = av; b = bv; sub = sv; in_valid = 1'b1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            acc = cyc;
            if (i > 0) begin
                vectors++;
                if (acc - prev !== 6) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: got %0d want 6", i, acc - prev);
                end
            end
            prev = acc;
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            ref_r = sv ? ({1'b0, av} + {1'b0, ~bv} + 33'd1) : ({1'b0, av} + {1'b0, bv});
            vectors++;
            if (sum !== ref_r[W-1:0] || cout !== ref_r[W] || n !== 4) begin
                miscompares++;
                $display("FAIL b2b_result[%0d]: a=%h b=%h sub=%b got %h/%b lat %0d want %h/%b lat 4",
                         i, av, bv, sv, sum, cout, n, ref_r[W-1:0], ref_r[W]);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_sub();
        test_stall();
        test_input_change();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
